// File: rtl/frame_decoder.sv
// rtl/frame_decoder.sv - receive-side 10-slot CRC8 frame decoder with sync tracking and statistics
module frame_decoder #(
  parameter logic [7:0] SOF_K       = 8'hBC,
  parameter logic [7:0] EOF_K       = 8'hFC,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter logic [7:0] CRC_INIT    = 8'hFF,
  parameter int         LOSS_THRESH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_valid,
  input  logic [7:0]  data_in,
  input  logic        k_in,
  input  logic        code_err,
  output logic [55:0] payload_out,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        frame_err,
  output logic        sync_o,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  localparam logic [1:0] S_HUNT    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_CRC     = 2'd2;
  localparam logic [1:0] S_EOF     = 2'd3;
  localparam logic [3:0] LOSS_M1   = 4'(LOSS_THRESH - 1);

  logic [1:0]  state, state_n;
  logic [2:0]  slot, slot_n;
  logic [7:0]  crc, crc_n;
  logic [55:0] shift, shift_n;
  logic        crc_ok, crc_ok_n;
  logic        fv_n, ce_n, fe_n;
  logic [3:0]  bad_run;

  // MSB-first, non-reflected CRC8 step over one byte
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ CRC_POLY) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    state_n  = state;
    slot_n   = slot;
    crc_n    = crc;
    shift_n  = shift;
    crc_ok_n = crc_ok;
    fv_n     = 1'b0;
    ce_n     = 1'b0;
    fe_n     = 1'b0;
    if (sym_valid) begin
      if (code_err && state != S_HUNT) begin
        fe_n    = 1'b1;
        state_n = S_HUNT;
      end else begin
        case (state)
          S_HUNT: begin
            if (k_in && data_in == SOF_K) begin
              crc_n   = CRC_INIT;
              slot_n  = 3'd1;
              state_n = S_PAYLOAD;
            end
          end
          S_PAYLOAD, S_CRC: begin
            if (k_in) begin
              fe_n = 1'b1;
              // an early SOF is taken as the start of a fresh frame
              if (data_in == SOF_K) begin
                crc_n   = CRC_INIT;
                slot_n  = 3'd1;
                state_n = S_PAYLOAD;
              end else begin
                state_n = S_HUNT;
              end
            end else if (state == S_PAYLOAD) begin
              shift_n = {shift[47:0], data_in};
              crc_n   = crc8_byte(crc, data_in);
              if (slot == 3'd7) state_n = S_CRC;
              else              slot_n  = slot + 3'd1;
            end else begin
              crc_ok_n = (data_in == crc);
              state_n  = S_EOF;
            end
          end
          S_EOF: begin
            if (k_in && data_in == EOF_K) begin
              fv_n = crc_ok;
              ce_n = !crc_ok;
            end else begin
              fe_n = 1'b1;
            end
            state_n = S_HUNT;
          end
          default: state_n = S_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_HUNT;
      slot        <= 3'd0;
      crc         <= CRC_INIT;
      shift       <= 56'd0;
      crc_ok      <= 1'b0;
      payload_out <= 56'd0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      sync_o      <= 1'b0;
      good_count  <= 16'd0;
      bad_count   <= 16'd0;
      bad_run     <= 4'd0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      crc         <= crc_n;
      shift       <= shift_n;
      crc_ok      <= crc_ok_n;
      frame_valid <= fv_n;
      crc_err     <= ce_n;
      frame_err   <= fe_n;
      if (fv_n) begin
        payload_out <= shift;
        sync_o      <= 1'b1;
        bad_run     <= 4'd0;
        if (good_count != 16'hFFFF) good_count <= good_count + 16'd1;
      end else if (ce_n || fe_n) begin
        if (bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
        if (bad_run != 4'hF)       bad_run   <= bad_run + 4'd1;
        // this error brings the consecutive-bad run up to the threshold
        if (bad_run >= LOSS_M1)    sync_o    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/frame_decoder.md
Name: frame_decoder

Overview:
- Receive-side counterpart of the 10-symbol CRC-protected frame encoder.
- Consumes the byte stream from the team's 8b10b decoder: byte, K flag, code-error flag and a symbol strobe.
- Finds frame boundaries, collects the 7 payload bytes and checks the CRC8.
- Presents good frames as a 56-bit word with a one-cycle strobe, and keeps sync status and saturating good/bad frame counters.

Parameters:
- SOF_K, 8'hBC, control byte expected in slot 0 (start of frame, K28.5).
- EOF_K, 8'hFC, control byte expected in slot 9 (end of frame, K28.7).
- CRC_POLY, 8'h07, CRC8 polynomial; must match the transmitter.
- CRC_INIT, 8'hFF, CRC8 seed value, loaded on each SOF.
- LOSS_THRESH, 3, number of consecutive bad frames that drops sync_o; range 1..15.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- sym_valid  in  1  data_in, k_in and code_err are valid this cycle.
- data_in  in  8  decoded byte.
- k_in  in  1  byte is a K (control) character.
- code_err  in  1  8b10b disparity or code violation on this symbol.
- payload_out  out  56  last good payload; slot 1 byte in [55:48], slot 7 byte in [7:0].
- frame_valid  out  1  one-cycle pulse; payload_out updated the same cycle.
- crc_err  out  1  one-cycle pulse: frame structure OK, CRC mismatch.
- frame_err  out  1  one-cycle pulse: structural error (unexpected K, bad EOF, code_err).
- sync_o  out  1  receiver in sync.
- good_count  out  16  good frames received, saturates at 16'hFFFF.
- bad_count  out  16  crc_err plus frame_err events, saturates at 16'hFFFF.

Behaviour:
- Frame format (slots 0..9):
  - slot 0: SOF_K (k=1)
  - slots 1..7: payload (k=0)
  - slot 8: CRC (k=0)
  - slot 9: EOF_K (k=1)
- CRC8 algorithm:
  - MSB-first, non-reflected, no final XOR.
  - Seeded with CRC_INIT when SOF is accepted.
  - Updated with each byte of slots 1..7 only.
  - Slot 8 byte must equal the accumulated CRC.
- Inputs are sampled only when sym_valid=1; all state holds otherwise.
- State machine states: HUNT, PAYLOAD (slot index 1..7), CRC, EOF.
  - HUNT: on k_in=1 and data_in==SOF_K, seed the CRC, set slot index to 1, go to PAYLOAD. Discard everything else silently (no error pulse).
  - PAYLOAD: a k=0 byte is shifted into the payload shift register and the CRC is updated. After slot 7, go to CRC.
  - PAYLOAD or CRC, k_in=1 received:
    - frame_err pulses.
    - If the byte is SOF_K, resynchronise: reseed the CRC, slot index=1, stay in/return to PAYLOAD.
    - Otherwise go to HUNT.
  - CRC: latch the compare result (k=0), go to EOF.
  - EOF: if k_in=1 and data_in==EOF_K, pulse frame_valid (CRC matched) or crc_err (CRC mismatched). Any other symbol pulses frame_err. Every outcome returns to HUNT.
- code_err=1 in any state other than HUNT:
  - frame_err pulses and the machine goes to HUNT.
  - This takes priority over all other decoding of that symbol.
- Output timing:
  - All pulses are registered and assert the cycle after the deciding symbol is sampled.
  - At most one of frame_valid, crc_err and frame_err is high in any cycle.
- payload_out changes only together with frame_valid; it holds its value on errors.
- Latency: frame_valid is high 1 clk after the EOF symbol is sampled.
- Sync:
  - sync_o goes high with the first frame_valid.
  - A 4-bit consecutive-bad counter increments on each crc_err or frame_err and clears on frame_valid.
  - sync_o drops when that counter reaches LOSS_THRESH. The counter saturates at 15.
- Statistic counters: good_count increments on frame_valid; bad_count increments on crc_err or frame_err. Both saturate and do not wrap.
- Reset (reset=0, asynchronous):
  - state=HUNT, CRC register=CRC_INIT.
  - payload_out=0, all pulses=0, sync_o=0, both counters=0.
  - Reset applied mid-frame discards the frame with no pulse.
- Back-to-back frames (EOF immediately followed by SOF) must be accepted with no gap symbol.

Test Plan:
- Good frame, payload 01 02 03 04 05 06 07 with CRC from the bench model, driven via sym_valid every cycle -> frame_valid 1 clk after EOF, payload_out=56'h01020304050607, sync_o=1, good_count=1.
- Same frame with the CRC byte XOR 8'h01 -> crc_err pulse, frame_valid=0, payload_out unchanged, bad_count=1.
- SOF inserted at slot 4, followed by a complete good frame -> frame_err once, then frame_valid with the new payload. Slot 9 = 8'hBC (k=1) instead of EOF -> frame_err.
- code_err at slot 5 -> frame_err; the remaining symbols are ignored until the next SOF; the next good frame is accepted.
- Three consecutive bad frames after sync (LOSS_THRESH=3) -> sync_o falls 1 clk after the third error; a following good frame -> sync_o=1.
- 100 back-to-back good frames with random sym_valid gaps, then reset=0 asserted mid-frame -> good_count=100 before reset; all outputs 0 immediately after reset; the partial frame produces no pulse.
